// File: rtl/icache.sv
// ============================================================================
// icache: direct-mapped, one-word-per-line instruction cache (IF <-> mem_ctrl)
// Rev 1.0
// ============================================================================
`default_nettype none

module icache #(
    parameter int INDEX_BITS = 7,
    parameter int TAG_BITS   = 16 - INDEX_BITS
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        rdy,
    input  logic        if_req,
    input  logic [31:0] if_pc,
    input  logic        flush,
    output logic        if_ok,
    output logic [31:0] if_inst,
    output logic        mem_req,
    output logic [31:0] mem_addr,
    input  logic [31:0] mem_data,
    input  logic        mem_ok
);

    localparam int LINES = 1 << INDEX_BITS;

    localparam logic [0:0] S_IDLE = 1'b0;
    localparam logic [0:0] S_MISS = 1'b1;

    logic [0:0]          state;
    logic                cancel;
    logic [LINES-1:0]    valid;
    logic [TAG_BITS-1:0] tag_mem  [LINES];
    logic [31:0]         data_mem [LINES];

    logic [INDEX_BITS-1:0] req_idx;
    logic [INDEX_BITS-1:0] fill_idx;
    logic [TAG_BITS-1:0]   req_tag;
    logic [TAG_BITS-1:0]   fill_tag;
    logic                  req_io;
    logic                  fill_io;
    logic                  hit;
    logic                  fill_en;

    assign req_idx  = if_pc[INDEX_BITS+1:2];
    assign req_tag  = if_pc[17:INDEX_BITS+2];
    assign req_io   = (if_pc[17:16] == 2'b11);

    // mem_addr holds the latched miss PC for the whole MISS state
    assign fill_idx = mem_addr[INDEX_BITS+1:2];
    assign fill_tag = mem_addr[17:INDEX_BITS+2];
    assign fill_io  = (mem_addr[17:16] == 2'b11);

    assign hit      = valid[req_idx] && (tag_mem[req_idx] == req_tag) && !req_io;
    assign fill_en  = rdy && (state == S_MISS) && mem_ok && !fill_io;

    always_ff @(posedge clk) begin
        if (fill_en) begin
            tag_mem[fill_idx]  <= fill_tag;
            data_mem[fill_idx] <= mem_data;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= S_IDLE;
            cancel   <= 1'b0;
            valid    <= '0;
            if_ok    <= 1'b0;
            if_inst  <= '0;
            mem_req  <= 1'b0;
            mem_addr <= '0;
        end else if (!rdy) begin
            if_ok <= 1'b0;
        end else begin
            if_ok <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (if_req && !flush) begin
                        if (hit) begin
                            if_ok   <= 1'b1;
                            if_inst <= data_mem[req_idx];
                        end else begin
                            mem_req  <= 1'b1;
                            mem_addr <= if_pc & 32'hFFFF_FFFC;
                            cancel   <= 1'b0;
                            state    <= S_MISS;
                        end
                    end
                end
                S_MISS: begin
                    if (flush) begin
                        cancel <= 1'b1;
                    end
                    if (mem_ok) begin
                        mem_req <= 1'b0;
                        state   <= S_IDLE;
                        if (!fill_io) begin
                            valid[fill_idx] <= 1'b1;
                        end
                        // A flush seen earlier or in this very cycle suppresses delivery only
                        if (!cancel && !flush) begin
                            if_ok   <= 1'b1;
                            if_inst <= mem_data;
                        end
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_icache.sv
// ============================================================================
// tb_icache: directed self-checking bench for icache with a cycle reference model
// Rev 1.0
// ============================================================================
`default_nettype none

module tb_icache;

    localparam int IB = 7;

    logic        clk;
    logic        rst_n;
    logic        rdy;
    logic        if_req;
    logic [31:0] if_pc;
    logic        flush;
    logic        if_ok;
    logic [31:0] if_inst;
    logic        mem_req;
    logic [31:0] mem_addr;
    logic [31:0] mem_data;
    logic        mem_ok;

    int errors = 0;
    int checks = 0;

    icache #(.INDEX_BITS(IB)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .rdy      (rdy),
        .if_req   (if_req),
        .if_pc    (if_pc),
        .flush    (flush),
        .if_ok    (if_ok),
        .if_inst  (if_inst),
        .mem_req  (mem_req),
        .mem_addr (mem_addr),
        .mem_data (mem_data),
        .mem_ok   (mem_ok)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model: lines keyed by index, holding the filled word address
    logic [31:0] line_wa [int];
    logic [31:0] line_d  [int];
    logic        m_busy, m_cancel;
    logic        e_ok, e_req;
    logic [31:0] e_inst, e_addr;

    function automatic int idx_of(input logic [31:0] pc);
        return int'((pc >> 2) % (1 << IB));
    endfunction

    function automatic logic is_io(input logic [31:0] pc);
        return pc[17:16] == 2'b11;
    endfunction

    function automatic logic m_hit(input logic [31:0] pc);
        logic [31:0] wa;
        if (is_io(pc) || !line_wa.exists(idx_of(pc))) return 1'b0;
        wa = line_wa[idx_of(pc)];
        return wa[17:2] == pc[17:2];
    endfunction

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            line_wa.delete();
            line_d.delete();
            m_busy = 0; m_cancel = 0;
            e_ok = 0; e_req = 0; e_inst = '0; e_addr = '0;
        end else if (!rdy) begin
            e_ok = 0;
        end else begin
            e_ok = 0;
            if (!m_busy) begin
                if (if_req && !flush) begin
                    if (m_hit(if_pc)) begin
                        e_ok = 1; e_inst = line_d[idx_of(if_pc)];
                    end else begin
                        m_busy = 1; m_cancel = 0; e_req = 1;
                        e_addr = {if_pc[31:2], 2'b00};
                    end
                end
            end else begin
                if (mem_ok) begin
                    if (!is_io(e_addr)) begin
                        line_wa[idx_of(e_addr)] = e_addr;
                        line_d[idx_of(e_addr)]  = mem_data;
                    end
                    if (!m_cancel && !flush) begin
                        e_ok = 1; e_inst = mem_data;
                    end
                    e_req = 0; m_busy = 0;
                end
                if (flush) m_cancel = 1;
            end
        end
    end

    always @(negedge clk) begin
        chk("if_ok",    {31'd0, if_ok},   {31'd0, e_ok});
        chk("if_inst",  if_inst,          e_inst);
        chk("mem_req",  {31'd0, mem_req}, {31'd0, e_req});
        chk("mem_addr", mem_addr,         e_addr);
    end

    // ---------------- IF + mem_ctrl driver
    task automatic fetch(input logic [31:0] pc, input int lat, input logic [31:0] d,
                         input int flush_at, output logic got, output int cyc,
                         output logic saw, output logic [31:0] addr, output logic [31:0] inst);
        int  seen;
        bit  done;
        seen = -1; got = 0; cyc = 0; saw = 0; addr = '0; inst = '0; done = 0;
        if_req = 1'b1; if_pc = pc;
        for (int k = 0; k < 40 && !done; k++) begin
            @(posedge clk); #2; cyc++;
            mem_ok = 1'b0; flush = 1'b0;
            if (if_ok) begin
                got = 1; inst = if_inst; done = 1;
            end else if (mem_req) begin
                if (!saw) addr = mem_addr;
                saw = 1; seen++;
                if (seen == flush_at) begin flush = 1'b1; if_req = 1'b0; end
                if (seen == lat) begin mem_ok = 1'b1; mem_data = d; if_req = 1'b0; end
            end else begin
                done = 1;
            end
        end
        if (!done) chk("fetch_timeout", 32'd1, 32'd0);
        if_req = 1'b0; mem_ok = 1'b0; flush = 1'b0;
        @(posedge clk); #2;
    endtask

    logic        got, saw;
    int          cyc;
    logic [31:0] addr, inst;

    initial begin
        rst_n = 1'b0; rdy = 1'b1; if_req = 1'b0; if_pc = '0; flush = 1'b0;
        mem_data = '0; mem_ok = 1'b0;
        repeat (2) @(posedge clk);
        #2;
        chk("rst_if_ok",   {31'd0, if_ok},   32'd0);
        chk("rst_mem_req", {31'd0, mem_req}, 32'd0);
        chk("rst_if_inst", if_inst,          32'd0);
        rst_n = 1'b1;
        @(posedge clk); #2;

        // cold miss on 0x0, then hit
        fetch(32'h0, 2, 32'h0000_0013, -1, got, cyc, saw, addr, inst);
        chk("t1_saw", {31'd0, saw}, 32'd1);
        chk("t1_addr", addr, 32'h0);
        chk("t1_got", {31'd0, got}, 32'd1);
        chk("t1_inst", inst, 32'h13);
        chk("t1_lat", cyc, 32'd4);
        fetch(32'h0, 2, 32'hDEAD_BEEF, -1, got, cyc, saw, addr, inst);
        chk("t2_saw", {31'd0, saw}, 32'd0);
        chk("t2_lat", cyc, 32'd1);
        chk("t2_inst", inst, 32'h13);

        // conflict eviction at index 0
        fetch(32'h200, 1, 32'h1111_0200, -1, got, cyc, saw, addr, inst);
        chk("t3_saw", {31'd0, saw}, 32'd1);
        chk("t3_addr", addr, 32'h200);
        chk("t3_inst", inst, 32'h1111_0200);
        fetch(32'h0, 1, 32'h0000_0013, -1, got, cyc, saw, addr, inst);
        chk("t3b_saw", {31'd0, saw}, 32'd1);
        chk("t3b_addr", addr, 32'h0);

        // flush two cycles before mem_ok: fill without delivery
        fetch(32'h104, 4, 32'h2222_0104, 2, got, cyc, saw, addr, inst);
        chk("t4_got", {31'd0, got}, 32'd0);
        fetch(32'h104, 1, 32'hDEAD_BEEF, -1, got, cyc, saw, addr, inst);
        chk("t4b_saw", {31'd0, saw}, 32'd0);
        chk("t4b_inst", inst, 32'h2222_0104);

        // rdy low for 3 edges while a hit is requested
        if_req = 1'b1; if_pc = 32'h0; rdy = 1'b0;
        repeat (3) begin
            @(posedge clk); #2;
            chk("t5_frozen", {31'd0, if_ok}, 32'd0);
        end
        rdy = 1'b1;
        @(posedge clk); #2;
        chk("t5_ok", {31'd0, if_ok}, 32'd1);
        chk("t5_inst", if_inst, 32'h13);
        if_req = 1'b0;
        @(posedge clk); #2;

        // back-to-back hits
        if_req = 1'b1; if_pc = 32'h0;
        @(posedge clk); #2;
        chk("t6_ok0", {31'd0, if_ok}, 32'd1);
        chk("t6_inst0", if_inst, 32'h13);
        if_pc = 32'h104;
        @(posedge clk); #2;
        chk("t6_ok1", {31'd0, if_ok}, 32'd1);
        chk("t6_inst1", if_inst, 32'h2222_0104);
        if_req = 1'b0;
        @(posedge clk); #2;

        // IO space never fills
        fetch(32'h3_0000, 1, 32'hDEAD_0001, -1, got, cyc, saw, addr, inst);
        chk("t7_saw", {31'd0, saw}, 32'd1);
        chk("t7_inst", inst, 32'hDEAD_0001);
        fetch(32'h3_0000, 1, 32'hDEAD_0002, -1, got, cyc, saw, addr, inst);
        chk("t7b_saw", {31'd0, saw}, 32'd1);
        chk("t7b_addr", addr, 32'h3_0000);
        fetch(32'h0, 1, 32'hDEAD_BEEF, -1, got, cyc, saw, addr, inst);
        chk("t7c_saw", {31'd0, saw}, 32'd0);
        chk("t7c_inst", inst, 32'h13);

        // flush and mem_ok in the same cycle
        fetch(32'h108, 1, 32'h3333_0108, 1, got, cyc, saw, addr, inst);
        chk("t8_got", {31'd0, got}, 32'd0);
        // stray mem_ok while idle must be ignored
        mem_ok = 1'b1; mem_data = 32'h0BAD_0BAD;
        @(posedge clk); #2;
        mem_ok = 1'b0;
        fetch(32'h108, 1, 32'hDEAD_BEEF, -1, got, cyc, saw, addr, inst);
        chk("t8b_saw", {31'd0, saw}, 32'd0);
        chk("t8b_inst", inst, 32'h3333_0108);

        // asynchronous reset in the middle of a miss
        if_req = 1'b1; if_pc = 32'h400;
        @(posedge clk); #2;
        chk("t9_req", {31'd0, mem_req}, 32'd1);
        if_req = 1'b0;
        #1 rst_n = 1'b0;
        #1;
        chk("t9_req_drop", {31'd0, mem_req}, 32'd0);
        chk("t9_addr_clr", mem_addr, 32'h0);
        @(posedge clk); #2;
        rst_n = 1'b1;
        @(posedge clk); #2;
        fetch(32'h104, 1, 32'h2222_0104, -1, got, cyc, saw, addr, inst);
        chk("t9_miss", {31'd0, saw}, 32'd1);
        chk("t9_inst", inst, 32'h2222_0104);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

`default_nettype wire
